sched_dispatch_ctrl: RTL and testbench

//  Local-scheduler dispatcher. Buffers decoded 5-bit scheduler commands (output of the opcode decoder) with
//  an address payload in a small in-order FIFO. Issues each to the PIM/PNM compute engine or the local memory

---
 rtl/sched_dispatch_ctrl_if.sv | 36 +++
 rtl/sched_dispatch_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sched_dispatch_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sched_dispatch_ctrl_if.sv
// Bundle between the scheduler dispatcher and its command source, compute engine and memory port.
// Every req/valid here is level-held by its source until the matching ack/gnt/ready is seen high on a rising edge.
interface sched_dispatch_ctrl_if #(parameter int ADDR_W = 16);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [4:0]        cmd_code;
  logic [ADDR_W-1:0] cmd_addr;
  logic              pim_req;
  logic [4:0]        pim_op;
  logic [ADDR_W-1:0] pim_addr;
  logic              pim_ack;
  logic              pim_done;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic              busy;
  logic [15:0]       done_cnt;
  logic              err_timeout;
  logic              err_illegal;
  logic [2:0]        dbg_state;

  modport slave (
    input  cmd_valid, cmd_code, cmd_addr, pim_ack, pim_done, mem_gnt, mem_rvalid,
    output cmd_ready, pim_req, pim_op, pim_addr, mem_req, mem_we, mem_size, mem_addr,
           busy, done_cnt, err_timeout, err_illegal, dbg_state
  );

  modport master (
    output cmd_valid, cmd_code, cmd_addr, pim_ack, pim_done, mem_gnt, mem_rvalid,
    input  cmd_ready, pim_req, pim_op, pim_addr, mem_req, mem_we, mem_size, mem_addr,
           busy, done_cnt, err_timeout, err_illegal, dbg_state
  );
endinterface

// File: rtl/sched_dispatch_ctrl.sv
// In-order command FIFO feeding a one-op-in-flight dispatcher to the compute engine or the memory port.
// Every wait state is bounded by TIMEOUT; an expired op is dropped and the queue carries on.
module sched_dispatch_ctrl #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  sched_dispatch_ctrl_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [2:0] {S_IDLE, S_PIM_REQ, S_PIM_WAIT, S_MEM_REQ, S_MEM_WAIT} state_t;
  typedef enum logic [2:0] {C_COMPUTE, C_LOAD, C_STORE, C_NOP, C_ILLEGAL} cls_t;

  state_t            state;
  logic [4:0]        fifo_code [DEPTH];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              full, empty, push, pop;
  logic [TW-1:0]     wcnt;
  logic              wait_expired;
  logic [4:0]        head_code;
  logic [ADDR_W-1:0] head_addr;
  cls_t              head_cls;

  function automatic cls_t classify(input logic [4:0] c);
    if (c[4])                   return C_COMPUTE;
    else if (c[3])              return (c[1:0] != 2'b00) ? C_LOAD : C_ILLEGAL;
    else if (c[2])              return C_ILLEGAL;
    else if (c[1:0] != 2'b00)   return C_STORE;
    else                        return C_NOP;
  endfunction

  assign full          = (count == (PW+1)'(DEPTH));
  assign empty         = (count == '0);
  assign push          = bus.cmd_valid && !full;
  assign pop           = (state == S_IDLE) && !empty;
  assign head_code     = fifo_code[rd_ptr];
  assign head_addr     = fifo_addr[rd_ptr];
  assign head_cls      = classify(head_code);
  assign wait_expired  = (wcnt == TW'(TIMEOUT - 1));
  assign bus.cmd_ready = !full;
  assign bus.busy      = !empty || (state != S_IDLE);
  assign bus.dbg_state = state;

  // Payload storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_code[wr_ptr] <= bus.cmd_code;
      fifo_addr[wr_ptr] <= bus.cmd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      wcnt            <= '0;
      bus.pim_req     <= 1'b0;
      bus.pim_op      <= '0;
      bus.pim_addr    <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_size    <= '0;
      bus.mem_addr    <= '0;
      bus.done_cnt    <= '0;
      bus.err_timeout <= 1'b0;
      bus.err_illegal <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (!empty) begin
          wcnt <= '0;
          case (head_cls)
            C_COMPUTE: begin
              state        <= S_PIM_REQ;
              bus.pim_req  <= 1'b1;
              bus.pim_op   <= head_code;
              bus.pim_addr <= head_addr;
            end
            C_LOAD, C_STORE: begin
              state        <= S_MEM_REQ;
              bus.mem_req  <= 1'b1;
              bus.mem_we   <= (head_cls == C_STORE);
              bus.mem_size <= head_code[1:0];
              bus.mem_addr <= head_addr;
            end
            C_NOP:   bus.done_cnt    <= bus.done_cnt + 16'd1;
            default: bus.err_illegal <= 1'b1;
          endcase
        end
        S_PIM_REQ: begin
          if (bus.pim_ack) begin
            bus.pim_req <= 1'b0;
            wcnt        <= '0;
            if (bus.pim_done) begin
              state        <= S_IDLE;
              bus.done_cnt <= bus.done_cnt + 16'd1;
            end else begin
              state <= S_PIM_WAIT;
            end
          end else if (wait_expired) begin
            bus.pim_req     <= 1'b0;
            bus.err_timeout <= 1'b1;
            state           <= S_IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_PIM_WAIT: begin
          if (bus.pim_done) begin
            state        <= S_IDLE;
            bus.done_cnt <= bus.done_cnt + 16'd1;
          end else if (wait_expired) begin
            bus.err_timeout <= 1'b1;
            state           <= S_IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_MEM_REQ: begin
          // A store completes on grant; a load completes on grant only if data returns with it.
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            wcnt        <= '0;
            if (bus.mem_we || bus.mem_rvalid) begin
              state        <= S_IDLE;
              bus.done_cnt <= bus.done_cnt + 16'd1;
            end else begin
              state <= S_MEM_WAIT;
            end
          end else if (wait_expired) begin
            bus.mem_req     <= 1'b0;
            bus.err_timeout <= 1'b1;
            state           <= S_IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_MEM_WAIT: begin
          if (bus.mem_rvalid) begin
            state        <= S_IDLE;
            bus.done_cnt <= bus.done_cnt + 16'd1;
          end else if (wait_expired) begin
            bus.err_timeout <= 1'b1;
            state           <= S_IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sched_dispatch_ctrl.sv
// Bench for sched_dispatch_ctrl: directed scenarios plus a randomized run, with a background
// responder for the engine/memory handshakes and an issue-order scoreboard.
module tb_sched_dispatch_ctrl;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sched_dispatch_ctrl_if #(.ADDR_W(ADDR_W)) bus();

  sched_dispatch_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [ADDR_W+4:0] exp_q[$];
  int exp_done = 0;
  bit exp_ill  = 1'b0;
  bit resp_en  = 1'b1;
  int ack_dly  = -1;
  int done_dly = -1;
  int gnt_dly  = -1;
  int rv_dly   = -1;

  // 0 compute, 1 load, 2 store, 3 nop, 4 illegal
  function automatic int cls(input logic [4:0] c);
    casez (c)
      5'b1????: return 0;
      5'b01?00: return 4;
      5'b01???: return 1;
      5'b00000: return 3;
      5'b000??: return 2;
      default:  return 4;
    endcase
  endfunction

  function automatic void model_accept(input logic [4:0] c, input logic [ADDR_W-1:0] a);
    if (cls(c) <= 2) exp_q.push_back({c, a});
    if (cls(c) == 4) exp_ill = 1'b1;
    else exp_done++;
  endfunction

  // Engine and memory responder
  initial begin : responder
    int ps, pc, ms, mc, d;
    ps = 0; pc = 0; ms = 0; mc = 0; d = 0;
    bus.pim_ack = 0; bus.pim_done = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0;
    forever begin
      @(posedge clk); #1;
      bus.pim_ack = 0; bus.pim_done = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0;
      if (rst || !resp_en) begin
        ps = 0; ms = 0;
      end else begin
        if (ps == 0 && bus.pim_req) begin
          pc = (ack_dly < 0) ? $urandom_range(0, 2) : ack_dly;
          ps = 1;
        end
        if (ps == 1) begin
          if (pc == 0) begin
            bus.pim_ack = 1;
            d = (done_dly < 0) ? $urandom_range(0, 3) : done_dly;
            if (d == 0) begin bus.pim_done = 1; ps = 0; end
            else begin pc = d; ps = 2; end
          end else pc--;
        end else if (ps == 2) begin
          pc--;
          if (pc == 0) begin bus.pim_done = 1; ps = 0; end
        end
        if (ms == 0 && bus.mem_req) begin
          mc = (gnt_dly < 0) ? $urandom_range(0, 2) : gnt_dly;
          ms = 1;
        end
        if (ms == 1) begin
          if (mc == 0) begin
            bus.mem_gnt = 1;
            if (bus.mem_we) ms = 0;
            else begin
              d = (rv_dly < 0) ? $urandom_range(0, 3) : rv_dly;
              if (d == 0) begin bus.mem_rvalid = 1; ms = 0; end
              else begin mc = d; ms = 2; end
            end
          end else mc--;
        end else if (ms == 2) begin
          mc--;
          if (mc == 0) begin bus.mem_rvalid = 1; ms = 0; end
        end
      end
    end
  end

  // Scoreboard: every new request must match the next issuable command in program order
  initial begin : monitor
    logic pp, pm, we_e;
    logic [4:0] ec;
    logic [ADDR_W-1:0] ea;
    pp = 0; pm = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst && bus.pim_req && !pp) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL issue_pim_unexpected got op=%b addr=%h exp none", bus.pim_op, bus.pim_addr);
        end else begin
          {ec, ea} = exp_q.pop_front();
          if (cls(ec) != 0 || bus.pim_op !== ec || bus.pim_addr !== ea) begin
            bad++; $display("FAIL issue_pim got op=%b addr=%h exp op=%b addr=%h", bus.pim_op, bus.pim_addr, ec, ea);
          end
        end
      end
      if (!rst && bus.mem_req && !pm) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL issue_mem_unexpected got addr=%h exp none", bus.mem_addr);
        end else begin
          {ec, ea} = exp_q.pop_front();
          we_e = (cls(ec) == 2);
          if ((cls(ec) != 1 && cls(ec) != 2) || {bus.mem_we, bus.mem_size, bus.mem_addr} !== {we_e, ec[1:0], ea}) begin
            bad++; $display("FAIL issue_mem got we=%b size=%b addr=%h exp code=%b addr=%h",
                            bus.mem_we, bus.mem_size, bus.mem_addr, ec, ea);
          end
        end
      end
      pp = bus.pim_req; pm = bus.mem_req;
    end
  end

  task automatic do_reset();
    rst = 1; bus.cmd_valid = 0; bus.cmd_code = '0; bus.cmd_addr = '0;
    resp_en = 1; ack_dly = -1; done_dly = -1; gnt_dly = -1; rv_dly = -1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    exp_q.delete(); exp_done = 0; exp_ill = 0;
  endtask

  task automatic push(input logic [4:0] c, input logic [ADDR_W-1:0] a);
    int n;
    n = 0;
    bus.cmd_valid = 1; bus.cmd_code = c; bus.cmd_addr = a;
    while (!bus.cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    total++;
    if (n >= 100) begin
      bad++; $display("FAIL push_stall got cmd_ready=0 for %0d cycles exp accept", n);
    end else begin
      @(posedge clk); #1;
      model_accept(c, a);
    end
    bus.cmd_valid = 0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (bus.busy && n < max_cyc) begin @(posedge clk); #1; n++; end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_timeout got busy=%b after %0d cycles exp 0", bus.busy, n); end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if ({bus.pim_req, bus.mem_req} !== 2'b00) begin bad++; $display("FAIL reset_req got=%b exp=00", {bus.pim_req, bus.mem_req}); end
    total++; if (bus.done_cnt !== 16'd0) begin bad++; $display("FAIL reset_done_cnt got=%0d exp=0", bus.done_cnt); end
    total++; if ({bus.err_timeout, bus.err_illegal} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {bus.err_timeout, bus.err_illegal}); end
    total++;
    if ({bus.pim_op, bus.pim_addr, bus.mem_we, bus.mem_size, bus.mem_addr} !== '0) begin
      bad++; $display("FAIL reset_payload got op=%b pa=%h we=%b sz=%b ma=%h exp all 0",
                      bus.pim_op, bus.pim_addr, bus.mem_we, bus.mem_size, bus.mem_addr);
    end
  endtask

  task automatic test_compute();
    int hi;
    do_reset();
    ack_dly = 1; done_dly = 3;
    push(5'b10000, 16'h0040);
    total++; if (bus.pim_req !== 1'b0) begin bad++; $display("FAIL compute_latency got pim_req=%b exp=0", bus.pim_req); end
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.pim_req) hi++;
      if (!bus.busy) break;
      @(posedge clk); #1;
    end
    total++; if (hi != 2) begin bad++; $display("FAIL compute_req_cycles got=%0d exp=2", hi); end
    total++; if (bus.pim_op !== 5'b10000 || bus.pim_addr !== 16'h0040) begin
      bad++; $display("FAIL compute_payload got op=%b addr=%h exp op=10000 addr=0040", bus.pim_op, bus.pim_addr); end
    total++; if (bus.done_cnt !== 16'd1) begin bad++; $display("FAIL compute_done_cnt got=%0d exp=1", bus.done_cnt); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL compute_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_mem_order();
    int n;
    logic prev;
    logic [2:0] seen [2];
    do_reset();
    gnt_dly = 0; rv_dly = 4;
    push(5'b01001, 16'h0100);
    push(5'b00011, 16'h0104);
    n = 0; prev = 0;
    seen[0] = '1; seen[1] = '1;
    for (int i = 0; i < 60; i++) begin
      if (bus.mem_req && !prev) begin
        if (n < 2) seen[n] = {bus.mem_we, bus.mem_size};
        n++;
      end
      prev = bus.mem_req;
      if (!bus.busy) break;
      @(posedge clk); #1;
    end
    total++; if (n != 2) begin bad++; $display("FAIL mem_issue_count got=%0d exp=2", n); end
    total++; if (seen[0] !== 3'b001) begin bad++; $display("FAIL mem_load_attr got we,size=%b exp=001", seen[0]); end
    total++; if (seen[1] !== 3'b111) begin bad++; $display("FAIL mem_store_attr got we,size=%b exp=111", seen[1]); end
    total++; if (bus.done_cnt !== 16'd2) begin bad++; $display("FAIL mem_done_cnt got=%0d exp=2", bus.done_cnt); end
    total++; if (bus.mem_addr !== 16'h0104) begin bad++; $display("FAIL mem_addr_hold got=%h exp=0104", bus.mem_addr); end
  endtask

  task automatic test_full();
    int acc;
    logic rdy;
    logic [4:0] c;
    logic [ADDR_W-1:0] a;
    do_reset();
    resp_en = 0;
    acc = 0;
    c = 5'($urandom_range(16, 31)); a = 16'($urandom);
    bus.cmd_valid = 1; bus.cmd_code = c; bus.cmd_addr = a;
    for (int i = 0; i < 10; i++) begin
      rdy = bus.cmd_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc++;
        model_accept(c, a);
        c = 5'($urandom_range(16, 31)); a = 16'($urandom);
        bus.cmd_code = c; bus.cmd_addr = a;
      end
      if (!bus.cmd_ready) break;
    end
    bus.cmd_valid = 0;
    total++; if (acc != DEPTH + 1) begin bad++; $display("FAIL full_accepted got=%0d exp=%0d", acc, DEPTH + 1); end
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL full_cmd_ready got=%b exp=0", bus.cmd_ready); end
    ack_dly = 0; resp_en = 1;
    wait_idle(300);
    total++; if (bus.done_cnt !== 16'(exp_done)) begin bad++; $display("FAIL full_done_cnt got=%0d exp=%0d", bus.done_cnt, exp_done); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL full_not_issued got=%0d pending exp=0", exp_q.size()); end
  endtask

  task automatic test_illegal();
    do_reset();
    push(5'b01000, 16'h1111);
    push(5'b00100, 16'h2222);
    total++; if (bus.err_illegal !== 1'b1) begin bad++; $display("FAIL illegal_flag_early got=%b exp=1", bus.err_illegal); end
    push(5'b00000, 16'h3333);
    wait_idle(50);
    total++; if (bus.done_cnt !== 16'd1) begin bad++; $display("FAIL illegal_done_cnt got=%0d exp=1", bus.done_cnt); end
    total++; if ({bus.err_illegal, bus.err_timeout} !== 2'b10) begin
      bad++; $display("FAIL illegal_flags got ill,to=%b exp=10", {bus.err_illegal, bus.err_timeout}); end
    total++; if ({bus.pim_op, bus.mem_addr} !== '0) begin
      bad++; $display("FAIL illegal_payload got op=%b ma=%h exp 0", bus.pim_op, bus.mem_addr); end
  endtask

  task automatic test_timeout();
    int hi;
    logic [ADDR_W-1:0] a2;
    do_reset();
    resp_en = 0;
    a2 = 16'($urandom);
    push(5'b10000, 16'($urandom));
    push(5'b01010, a2);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.pim_req) hi++;
      else if (hi > 0) break;
      @(posedge clk); #1;
    end
    total++; if (hi != TIMEOUT) begin bad++; $display("FAIL timeout_req_cycles got=%0d exp=%0d", hi, TIMEOUT); end
    total++; if (bus.err_timeout !== 1'b1) begin bad++; $display("FAIL timeout_flag got=%b exp=1", bus.err_timeout); end
    resp_en = 1;
    wait_idle(60);
    total++; if (bus.done_cnt !== 16'(exp_done - 1)) begin bad++; $display("FAIL timeout_done_cnt got=%0d exp=%0d", bus.done_cnt, exp_done - 1); end
    total++; if ({bus.mem_we, bus.mem_size, bus.mem_addr} !== {1'b0, 2'b10, a2}) begin
      bad++; $display("FAIL timeout_next_load got we=%b size=%b addr=%h exp we=0 size=10 addr=%h",
                      bus.mem_we, bus.mem_size, bus.mem_addr, a2); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL timeout_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    gnt_dly = 0; rv_dly = 50;
    push(5'b00000, 16'h0000);
    push(5'b01001, 16'h0200);
    for (int i = 0; i < 3; i++) push(5'($urandom_range(16, 31)), 16'($urandom));
    total++; if ({bus.busy, bus.mem_req} !== 2'b10) begin
      bad++; $display("FAIL midrst_pre got busy,mem_req=%b exp=10", {bus.busy, bus.mem_req}); end
    total++; if (bus.done_cnt !== 16'd1) begin bad++; $display("FAIL midrst_pre_cnt got=%0d exp=1", bus.done_cnt); end
    rst = 1;
    @(posedge clk); #1;
    total++; if ({bus.mem_req, bus.pim_req, bus.busy} !== 3'b000) begin
      bad++; $display("FAIL midrst_outputs got mem_req,pim_req,busy=%b exp=000", {bus.mem_req, bus.pim_req, bus.busy}); end
    total++; if (bus.done_cnt !== 16'd0) begin bad++; $display("FAIL midrst_done_cnt got=%0d exp=0", bus.done_cnt); end
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_cmd_ready got=%b exp=1", bus.cmd_ready); end
    total++; if (bus.mem_addr !== '0) begin bad++; $display("FAIL midrst_mem_addr got=%h exp=0", bus.mem_addr); end
    rst = 0;
    exp_q.delete(); exp_done = 0; exp_ill = 0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_flushed got busy=%b exp=0", bus.busy); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      push(5'($urandom_range(0, 31)), 16'($urandom));
    end
    wait_idle(3000);
    total++; if (bus.done_cnt !== 16'(exp_done)) begin bad++; $display("FAIL random_done_cnt got=%0d exp=%0d", bus.done_cnt, exp_done); end
    total++; if (bus.err_illegal !== exp_ill) begin bad++; $display("FAIL random_err_illegal got=%b exp=%b", bus.err_illegal, exp_ill); end
    total++; if (bus.err_timeout !== 1'b0) begin bad++; $display("FAIL random_err_timeout got=%b exp=0", bus.err_timeout); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL random_pending got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_compute();
    test_mem_order();
    test_full();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
